ysyx_22040127_mem_arbiter: RTL
==============================

Name: ysyx_22040127_mem_arbiter

Overview:
- Round-robin arbiter sharing one memory port between NR_REQ requesters, e.g. IFU = index 0 and LSU = index 1 in the NPC.
- Only one transaction is outstanding at a time.
- A request/response FSM sequences the address phase and the response phase.
- Request fields go out through a grant-indexed mux; the response is routed back through a one-hot decode of the latched grant.

Parameters:
- NR_REQ, 2, number of requesters (2..8).
- ADDR_W, 64, address width.
- DATA_W, 64, data width; write mask is DATA_W/8 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NR_REQ  per-requester request valid.
- req_ready  out  NR_REQ  per-requester request accepted.
- req_addr  in  NR_REQ*ADDR_W  packed addresses; requester n occupies [ADDR_W*(n+1)-1 : ADDR_W*n].
- req_wen  in  NR_REQ  1 = write, 0 = read.
- req_wdata  in  NR_REQ*DATA_W  packed write data.
- req_wmask  in  NR_REQ*DATA_W/8  packed byte masks.
- resp_valid  out  NR_REQ  one-hot, one-cycle response strobe.
- resp_rdata  out  DATA_W  shared read data; qualified by resp_valid.
- mem_valid  out  1  downstream request valid.
- mem_ready  in  1  downstream request accepted.
- mem_addr  out  ADDR_W  downstream address.
- mem_wen  out  1  downstream write enable.
- mem_wdata  out  DATA_W  downstream write data.
- mem_wmask  out  DATA_W/8  downstream byte mask.
- mem_resp_valid  in  1  downstream response strobe (reads and writes).
- mem_rdata  in  DATA_W  downstream read data.

Behaviour:
- Reset: state=IDLE, grant=0, ptr=0. Outputs after reset: req_ready=0, resp_valid=0, mem_valid=0, mem_addr/mem_wdata/mem_wmask/mem_wen/resp_rdata=0.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching ptr, ptr+1, … wrapping modulo NR_REQ.
  - Latch it into grant and go to ADDR.
  - Otherwise stay in IDLE.
  - No outputs are asserted in IDLE.
- ADDR:
  - mem_valid = req_valid[grant].
  - mem_addr/wen/wdata/wmask = requester grant's fields, muxed combinationally (not latched).
  - req_ready[grant] = mem_ready; all other req_ready bits are 0.
  - If req_valid[grant] && mem_ready: handshake, go to RESP.
  - If req_valid[grant]=0 (requester withdrew): go to IDLE, ptr unchanged, nothing issued.
- RESP:
  - All mem_valid and req_ready are 0.
  - On mem_resp_valid: resp_valid[grant]=1 for that cycle only, resp_rdata=mem_rdata (combinational passthrough), go to IDLE, ptr = grant+1 mod NR_REQ.
- Outside RESP, resp_valid=0 and resp_rdata=0.
- Latency:
  - req_valid rising in IDLE at cycle N gives mem_valid at N+1.
  - If mem_ready=1 at N+1, the earliest response (mem_resp_valid at N+2) is visible on resp_valid at N+2.
  - Minimum turnaround is 3 cycles per transaction; a new arbitration occurs in the IDLE cycle after the response.
- mem_resp_valid outside RESP is ignored; it produces no resp_valid and no state change.
- mem_resp_valid in the same cycle as the ADDR handshake is ignored; the response must arrive at least one cycle after the handshake.
- Fairness: after requester k is served, k has lowest priority. With all requesters asserted continuously, grants rotate 0,1,…,NR_REQ-1,0.
- Simultaneous requests in IDLE: exactly one grant per transaction. Losers keep req_ready=0 and must hold valid.
- Requester grant changing its fields while in ADDR before the handshake is permitted; mem_* follows the change.
- rst asserted in any state:
  - Next cycle: IDLE, ptr=0, all outputs 0.
  - An in-flight downstream response arriving after reset is ignored (falls in IDLE).
- Grant index width is clog2(NR_REQ), minimum 1. Pointer increment wraps at NR_REQ, not at a power of two.

Test Plan:
- Single read: req_valid=01, req_addr[0]=0x80000000, mem_ready=1, mem_resp_valid at +1 after handshake with mem_rdata=0xDEADBEEF00000013 -> mem_valid at cycle 1 with mem_addr=0x80000000 and wen=0; req_ready=01 at cycle 1; resp_valid=01 and resp_rdata=0xDEADBEEF00000013 at cycle 2.
- Contention: req_valid=11 held, mem_ready=1, response 1 cycle after each handshake -> grants 0,1,0,1. resp_valid pattern: 01,10,01,10, 3 cycles apart.
- Backpressure: mem_ready=0 for 4 cycles in ADDR -> mem_valid held at 1, mem_addr stable, req_ready[grant]=0. Handshake on the 5th cycle, then RESP.
- Write from requester 1: wen=1, wdata=0x1122334455667788, wmask=0x0F -> mem_wen=1 and mem_wdata/wmask passed exactly. resp_valid=10 on mem_resp_valid.
- Withdrawal and spurious response: req_valid[0] dropped in ADDR -> IDLE next cycle, no handshake, ptr still 0. A mem_resp_valid pulse in IDLE -> resp_valid stays 0.
- Reset mid-op: rst=1 during RESP, then a late mem_resp_valid -> all outputs 0, no resp_valid. With req_valid=11 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NR_REQ requesters.
// One transaction in flight; address phase then response phase.
module ysyx_22040127_mem_arbiter #(
    parameter int NR_REQ = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR_REQ-1:0]          req_valid,
    output logic [NR_REQ-1:0]          req_ready,
    input  logic [NR_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NR_REQ-1:0]          req_wen,
    input  logic [NR_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NR_REQ*DATA_W/8-1:0] req_wmask,
    output logic [NR_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_wen,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wmask,
    input  logic                       mem_resp_valid,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int IW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int MW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic [2*NR_REQ-1:0] rot;
    logic [IW:0]         pick_sum;
    logic [IW-1:0]       pick;
    logic                any_req;

    logic [NR_REQ-1:0]   grant_oh;
    logic                gnt_valid;
    logic                gnt_wen;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;
    logic [MW-1:0]       gnt_wmask;

    // Rotate so bit 0 is the requester at ptr; lowest set bit wins.
    always_comb begin
        rot      = {req_valid, req_valid} >> ptr_q;
        any_req  = 1'b0;
        pick_sum = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_sum = {1'b0, ptr_q} + (IW+1)'(i);
                any_req  = 1'b1;
            end
        end
        if (pick_sum >= (IW+1)'(NR_REQ))
            pick_sum = pick_sum - (IW+1)'(NR_REQ);
        pick = pick_sum[IW-1:0];
    end

    always_comb begin
        grant_oh  = '0;
        gnt_valid = 1'b0;
        gnt_wen   = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        gnt_wmask = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                grant_oh[i] = 1'b1;
                gnt_valid   = req_valid[i];
                gnt_wen     = req_wen[i];
                gnt_addr    = req_addr[i*ADDR_W +: ADDR_W];
                gnt_wdata   = req_wdata[i*DATA_W +: DATA_W];
                gnt_wmask   = req_wmask[i*MW +: MW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!gnt_valid)
                    state_d = IDLE;
                else if (mem_ready)
                    state_d = RESP;
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == IW'(NR_REQ - 1)) ? '0
                                                           : grant_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_wen    = 1'b0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        unique case (state_q)
            ADDR: begin
                mem_valid = gnt_valid;
                mem_addr  = gnt_addr;
                mem_wen   = gnt_wen;
                mem_wdata = gnt_wdata;
                mem_wmask = gnt_wmask;
                req_ready = grant_oh & {NR_REQ{mem_ready}};
            end
            RESP: begin
                if (mem_resp_valid) begin
                    resp_valid = grant_oh;
                    resp_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
